// File: rtl/instr_fetch_if.sv
// Instruction-side bus between the fetch unit (master) and the code RAM (slave).
// Grant is combinational in the request cycle; rvalid/rdata follow one cycle later.
interface instr_bus;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: issues code-RAM requests under a credit limit and queues
// {pc, instr} pairs for decode; redirects flush the queue and drop in-flight data.
module instr_fetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  instr_bus.master    ibus,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Handshakes: req/addr hold until gnt; a grant returns exactly one rvalid
  // next cycle; decode takes the head when out_valid & out_ready are both high.

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  cnt_t        outst_q, outst_d;
  cnt_t        discard_q, discard_d;
  cnt_t        count_q, count_d;
  ptr_t        rptr_q, rptr_d;
  ptr_t        wptr_q, wptr_d;
  logic [31:0] mem_pc_q    [FIFO_DEPTH];
  logic [31:0] mem_instr_q [FIFO_DEPTH];

  logic        grant;
  logic        resp_live;
  logic        push;
  logic        pop;
  logic [CW:0] credit_used;
  logic [31:0] redirect_aligned;
  logic        unused_pc_bits;

  assign unused_pc_bits   = ^redirect_pc[1:0];
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign credit_used      = {1'b0, count_q} + {1'b0, outst_q};

  // Request is also held low during reset so nothing is granted that reset would orphan.
  assign ibus.req  = !rst && fetch_en && !redirect_valid && (credit_used < DEPTH_C);
  assign ibus.addr = fetch_pc_q;

  assign out_valid = (count_q != '0) && !redirect_valid;
  assign out_pc    = mem_pc_q[rptr_q];
  assign out_instr = mem_instr_q[rptr_q];

  always_comb begin
    grant     = ibus.req && ibus.gnt;
    // A response with nothing outstanding belongs to a pre-reset request.
    resp_live = ibus.rvalid && (outst_q != '0);
    push      = resp_live && !redirect_valid && (discard_q == '0);
    pop       = out_valid && out_ready;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    outst_d    = outst_q + cnt_t'(grant) - cnt_t'(resp_live);

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      discard_d  = outst_q - cnt_t'(resp_live);
      count_d    = '0;
      rptr_d     = '0;
      wptr_d     = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_live && (discard_q != '0)) discard_d = discard_q - cnt_t'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wptr_d    = wptr_q + ptr_t'(1);
      end
      if (pop) rptr_d = rptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      if (push) begin
        mem_pc_q[wptr_q]    <= resp_pc_q;
        mem_instr_q[wptr_q] <= ibus.rdata;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: one-cycle code RAM model, queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        gnt_en = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  instr_bus ibus ();

  instr_fetch #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .ibus           (ibus),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- code RAM ----------------
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign ibus.gnt = gnt_en;

  initial begin
    ibus.rvalid = 1'b0;
    ibus.rdata  = '0;
  end

  always @(posedge clk) begin
    ibus.rvalid <= ibus.req & ibus.gnt;
    ibus.rdata  <= ram_word(ibus.addr);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: exp_q holds {pc, instr} waiting for decode, infl_q holds
  // {stale, addr} for every granted request not yet answered.
  logic [63:0] exp_q[$];
  logic [32:0] infl_q[$];
  logic [32:0] m_resp;
  logic [31:0] m_fetch_pc = RST_PC;
  logic        m_req;
  logic        m_ov;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      infl_q.delete();
      m_fetch_pc = RST_PC;
    end else begin
      m_req = fetch_en && !redirect_valid && ((exp_q.size() + infl_q.size()) < DEPTH);
      m_ov  = (exp_q.size() != 0) && !redirect_valid;
      chk("req", 32'(ibus.req), 32'(m_req));
      if (m_req) chk("addr", ibus.addr, m_fetch_pc);
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("out_pc", out_pc, exp_q[0][63:32]);
        chk("out_instr", out_instr, exp_q[0][31:0]);
      end
      if (m_ov && out_ready) void'(exp_q.pop_front());
      if (ibus.rvalid && infl_q.size() != 0) begin
        m_resp = infl_q.pop_front();
        if (!redirect_valid && !m_resp[32])
          exp_q.push_back({m_resp[31:0], ram_word(m_resp[31:0])});
      end
      if (m_req && gnt_en) begin
        infl_q.push_back({1'b0, m_fetch_pc});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        foreach (infl_q[i]) infl_q[i][32] = 1'b1;
        exp_q.delete();
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] a0;

  initial begin
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(ibus.req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);

    // Streaming from RESET_PC
    tick();
    fetch_en = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(ibus.req), 32'd1);
    chk("first_addr", ibus.addr, 32'h0000_0100);
    tick();
    @(negedge clk);
    chk("fill_no_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_pc", out_pc, 32'h0000_0100);
    chk("first_instr", out_instr, 32'h0100_FEFF);
    repeat (8) tick();

    // Decode stalls: FIFO fills and credit stops requests
    out_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("full_req_low", 32'(ibus.req), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    repeat (8) tick();

    // Grant withheld for 3 cycles
    tick();
    gnt_en = 1'b0;
    @(negedge clk);
    chk("stall_req", 32'(ibus.req), 32'd1);
    a0 = ibus.addr;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("stall_req_hold", 32'(ibus.req), 32'd1);
      chk("stall_addr_hold", ibus.addr, a0);
    end
    tick();
    gnt_en = 1'b1;
    repeat (6) tick();

    // Redirect coinciding with the single outstanding response
    fetch_en = 1'b0;
    repeat (6) tick();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2002;
    @(negedge clk);
    chk("redir_rvalid", 32'(ibus.rvalid), 32'd1);
    chk("redir_out_valid", 32'(out_valid), 32'd0);
    chk("redir_req", 32'(ibus.req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    @(negedge clk);
    chk("redir_new_req", 32'(ibus.req), 32'd1);
    chk("redir_new_addr", ibus.addr, 32'h0000_2000);
    tick();
    @(negedge clk);
    chk("redir_r2_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("redir_r3_valid", 32'(out_valid), 32'd1);
    chk("redir_r3_pc", out_pc, 32'h0000_2000);
    chk("redir_r3_instr", out_instr, 32'h2000_DFFF);
    repeat (4) tick();

    // Redirect with 3 entries queued and decode ready
    out_ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("fill4_req_low", 32'(ibus.req), 32'd0);
    tick();
    fetch_en = 1'b0;
    out_ready = 1'b1;
    tick();
    fetch_en = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    @(negedge clk);
    chk("flush_valid_r", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid_r1", 32'(out_valid), 32'd0);
    chk("flush_addr_r1", ibus.addr, 32'h0000_3000);
    repeat (6) tick();

    // Reset with a response in flight
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_inflight_rvalid", 32'(ibus.rvalid), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_out_pc", out_pc, 32'd0);
    chk("rst2_out_instr", out_instr, 32'd0);
    chk("rst2_addr", ibus.addr, 32'h0000_0100);
    tick();
    tick();
    @(negedge clk);
    chk("rst2_first_pc", out_pc, 32'h0000_0100);

    // Mixed traffic checked by the model alone
    repeat (60) begin
      tick();
      gnt_en         = 1'($urandom_range(0, 1));
      out_ready      = 1'($urandom_range(0, 1));
      fetch_en       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
    end
    tick();
    redirect_valid = 1'b0;
    fetch_en = 1'b0;
    out_ready = 1'b1;
    gnt_en = 1'b1;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the `instr_bus` protocol, driving requests into the code RAM's instruction port. It keeps a small in-order prefetch FIFO that hands {pc, instr} pairs to decode through a valid/ready handshake. Redirects from branches, jumps and traps flush the FIFO and discard responses already in flight. It sits between the code RAM, with its data-side-priority arbitration, and the core's decode stage.

## Interface
- `FIFO_DEPTH`, default 4: prefetch entries; a power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; word-aligned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ibus`  instr_bus.master  —  drives `req` and `addr[31:0]`; samples `gnt`, `rvalid` and `rdata[31:0]`.
- `fetch_en`  in  1  permits issue of new requests.
- `redirect_valid`  in  1  single-cycle flush and restart pulse.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  decode accepts the head.
- `out_instr`  out  32  instruction word at the FIFO head.
- `out_pc`  out  32  address of `out_instr`.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - `resp_pc`: address of the next expected response.
  - `outstanding`: granted but not yet returned requests, range 0..FIFO_DEPTH.
  - `discard`: responses still to drop.
  - FIFO: storage plus read pointer, write pointer and count.
- Issue:
  - `ibus.req = fetch_en & !redirect_valid & (count + outstanding < FIFO_DEPTH)`.
  - `ibus.addr = fetch_pc`.
  - The credit rule means a FIFO overflow is impossible.
- Grant:
  - `req & gnt` in the same cycle: `fetch_pc += 4` (wraps mod 2^32) and `outstanding++`.
  - `req` without `gnt` has no side effect. The request is re-presented with the same `addr` next cycle, unless a redirect intervenes.
- Response: `rvalid` decrements `outstanding`.
  - If `discard > 0`: decrement `discard` and drop `rdata`.
  - Otherwise: push {`resp_pc`, `rdata`} and set `resp_pc += 4`.
- Pop: `out_valid & out_ready & !redirect_valid` advances the read pointer.
- Push and pop in the same cycle: `count` is unchanged.
- Redirect:
  - `fetch_pc` and `resp_pc` take `{redirect_pc[31:2], 2'b00}`.
  - FIFO count and pointers are cleared.
  - `discard` takes the value of `outstanding` after this cycle's `rvalid` is applied, i.e. `outstanding - rvalid`.
  - A response arriving in the redirect cycle is dropped.
  - `discard` takes priority over pushes.
- `fetch_en` low: no new requests; in-flight responses are still accepted and pushed.
- `out_valid = (count != 0) & !redirect_valid`.
- `out_instr` and `out_pc` show the FIFO head entry.
- Reset, sampled at the clock edge:
  - `fetch_pc = resp_pc = RESET_PC`.
  - `outstanding = discard = 0`; FIFO empty; storage zeroed.
  - `ibus.req = 0`, `out_valid = 0`, `out_instr = 0`, `out_pc = 0`.
  - Responses to requests issued before reset arrive while `outstanding = discard = 0` and are not pushed.

## Timing
- Grant in cycle T (combinational from the RAM) -> `rvalid`/`rdata` in T+1 -> `out_valid` in T+2 with the matching `out_pc`. There is no FIFO bypass.
- With `out_ready` held high and `gnt` every cycle, throughput is one instruction per cycle after a 2-cycle fill.
- The first request after reset deassertion is issued in the same cycle if `fetch_en = 1`.
- Redirect in cycle R:
  - `req = 0` and `out_valid = 0` in R.
  - First request to the new PC in R+1.
  - First new instruction at `out_valid` in R+3 if the request is granted in R+1.
- Back-to-back redirects: the last one wins; `discard` is recomputed each time.
- `gnt` low because the data port has priority: `req` and `addr` stay stable, and `outstanding` does not change.

## Test plan
- Reset with `RESET_PC = 32'h100`, `fetch_en = 1`, RAM granting every cycle, `out_ready = 1` -> `out_pc` sequence 0x100, 0x104, 0x108…, with `out_instr` matching the RAM contents; first `out_valid` 2 cycles after the first grant.
- `out_ready = 0` for 10 cycles -> exactly FIFO_DEPTH (4) entries held; `req` drops once `count + outstanding = 4`; no lost or duplicated PCs when `out_ready` returns to 1.
- `gnt` low for 3 cycles mid-stream (dbus contention) -> `addr` held constant and `req` held high; fetch resumes at the same address; PC sequence stays contiguous.
- `redirect_valid` with `redirect_pc = 32'h2002` in the cycle an `rvalid` returns, with one request outstanding -> that response is dropped; next `out_pc = 32'h2000`; no stale instruction reaches decode.
- Redirect while the FIFO holds 3 entries, with a simultaneous `out_ready = 1` -> no pop occurs; `out_valid = 0` in that cycle and the next; the FIFO restarts empty.
- `rst` asserted with a request in flight -> all outputs return to reset values the next cycle; the late `rvalid` is not pushed; fetch restarts at `RESET_PC`.
